muldiv_sequencer: RTL and testbench

// - Multi-cycle sequencer for mult/multu/div/divu; owns the HI/LO register pair.
// - Sits beside the single-cycle ALU in EX: ALU forwards the op and operands, reads hilo_q, and issues mthi/mtlo here.
// - Raises stall_req to freeze the pipeline whenever HI/LO is touched while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 27 ++
 rtl/muldiv_sequencer.sv | 135 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the mult/div sequencer and its iteration step.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  localparam int          ITER_LAST       = 31;
  localparam logic [31:0] DIV0_LO_DEFAULT = 32'hFFFF_FFFF;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
// acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
module muldiv_step (
  input  logic        is_div_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o
);

  logic [32:0] add_sum;
  logic [32:0] part_rem;
  logic [33:0] sub_diff;

  always_comb begin
    add_sum  = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
    part_rem = acc_i[63:31];
    sub_diff = {1'b0, part_rem} - {2'b00, opnd_i};
    if (is_div_i) begin
      // Borrow out means the divisor did not fit: keep the shifted remainder.
      if (sub_diff[33]) acc_o = {part_rem[31:0], acc_i[30:0], 1'b0};
      else              acc_o = {sub_diff[31:0], acc_i[30:0], 1'b1};
    end else begin
      acc_o = {add_sum, acc_i[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner and multi-cycle mult/div sequencer; 34-cycle iterative ops, 2-cycle divide-by-zero.
// MULDIV_FAST_MULT_EN: mult/multu skip RUN and use a single-cycle 64-bit multiply.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int          ITER_BITS = 6,
  parameter logic [31:0] DIV0_LO   = DIV0_LO_DEFAULT
) (
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        mt_en,
  input  logic        mt_hi,
  input  logic        mf_req,
  output logic [63:0] hilo_q,
  output logic        busy,
  output logic        done,
  output logic        stall_req
);

  state_e               state_q;
  logic [ITER_BITS-1:0] cnt_q;
  logic [63:0]          acc_q;
  logic [31:0]          opnd_q;
  logic                 is_div_q, sign_q, sign_r_q, raw_q;
  logic                 busy_q, done_q;

  op_e         op_w;
  logic        is_div_w, is_signed_w;
  logic [31:0] abs_a, abs_b, rem_fix, quo_fix;
  logic [63:0] step_acc, prod_fix, fix_res;

  assign op_w        = op_e'(op);
  assign is_div_w    = (op_w == OP_DIV) || (op_w == OP_DIVU);
  assign is_signed_w = (op_w == OP_MULT) || (op_w == OP_DIV);
  assign abs_a       = is_signed_w ? abs32(rs) : rs;
  assign abs_b       = is_signed_w ? abs32(rt) : rt;

  muldiv_step u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    rem_fix  = sign_r_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    quo_fix  = sign_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    prod_fix = sign_q ? (~acc_q + 64'd1) : acc_q;
    if (raw_q)         fix_res = acc_q;
    else if (is_div_q) fix_res = {rem_fix, quo_fix};
    else               fix_res = prod_fix;
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      sign_r_q <= 1'b0;
      raw_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hilo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            is_div_q <= is_div_w;
            sign_q   <= is_signed_w & (rs[31] ^ rt[31]);
            sign_r_q <= is_signed_w & rs[31];
            cnt_q    <= '0;
            opnd_q   <= abs_b;
            acc_q    <= {32'd0, abs_a};
            raw_q    <= 1'b0;
            busy_q   <= 1'b1;
            if (is_div_w && (rt == 32'd0)) begin
              // Result is fixed by definition; FIX writes acc untouched.
              acc_q   <= {rs, DIV0_LO};
              raw_q   <= 1'b1;
              state_q <= ST_FIX;
              done_q  <= 1'b1;
`ifdef MULDIV_FAST_MULT_EN
            end else if (!is_div_w) begin
              acc_q   <= {32'd0, abs_a} * {32'd0, abs_b};
              state_q <= ST_FIX;
              done_q  <= 1'b1;
`endif
            end else begin
              state_q <= ST_RUN;
            end
          end else if (mt_en) begin
            if (mt_hi) hilo_q[63:32] <= rs;
            else       hilo_q[31:0]  <= rs;
          end
        end
        ST_RUN: begin
          acc_q <= step_acc;
          if (cnt_q == ITER_BITS'(ITER_LAST)) begin
            cnt_q   <= '0;
            state_q <= ST_FIX;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ITER_BITS'(1);
          end
        end
        ST_FIX: begin
          hilo_q  <= fix_res;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign stall_req = busy_q & (start | mt_en | mf_req);

  // A single EX instruction can never be both a mult/div and an mthi/mtlo.
  a_no_start_with_mt: assert property (@(posedge clk_cpu) disable iff (reset)
                                       !(start && mt_en && !busy_q));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus stall, mthi/mtlo and reset sequences.
module tb_muldiv_sequencer;

  logic        clk_cpu = 1'b0;
  logic        reset, start, mt_en, mt_hi, mf_req;
  logic [1:0]  op;
  logic [31:0] rs, rt;
  logic [63:0] hilo_q;
  logic        busy, done, stall_req;

  int total = 0;
  int bad   = 0;

`ifdef MULDIV_FAST_MULT_EN
  localparam int          ML   = 1;
  localparam logic [1:0]  D_OP = 2'b11;
`else
  localparam int          ML   = 33;
  localparam logic [1:0]  D_OP = 2'b01;
`endif

  muldiv_sequencer dut (
    .clk_cpu   (clk_cpu),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .mt_en     (mt_en),
    .mt_hi     (mt_hi),
    .mf_req    (mf_req),
    .hilo_q    (hilo_q),
    .busy      (busy),
    .done      (done),
    .stall_req (stall_req)
  );

  always #5 clk_cpu = ~clk_cpu;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  initial begin
    int          lat;
    logic        done_seen;
    logic [63:0] prev;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, ML};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, ML};
    vecs[2]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, ML};
    vecs[3]  = '{2'b01, 32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340, ML};
    vecs[4]  = '{2'b00, 32'h0000_0005, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFEC, ML};
    vecs[5]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    vecs[6]  = '{2'b11, 32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003, 33};
    vecs[7]  = '{2'b11, 32'h0000_0005, 32'h0000_0000, 64'h0000_0005_FFFF_FFFF, 1};
    vecs[8]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33};
    vecs[9]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF, 33};
    vecs[10] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33};
    vecs[11] = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFF_FFFB_FFFF_FFFF, 1};

    reset = 1'b1; start = 1'b0; mt_en = 1'b0; mt_hi = 1'b0; mf_req = 1'b0;
    op = 2'b00; rs = '0; rt = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk_cpu);
    chk("rst_hilo", hilo_q, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    tick();
    mf_req = 1'b1;
    @(negedge clk_cpu);
    chk("idle_mf_stall", {63'd0, stall_req}, 64'd0);
    tick();
    mf_req = 1'b0;

    for (int v = 0; v < 12; v++) begin
      start = 1'b1; op = vecs[v].op; rs = vecs[v].rs; rt = vecs[v].rt;
      tick();
      start = 1'b0; rs = '0; rt = '0;
      lat = -1;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
        @(negedge clk_cpu);
        if (k == 1) chk($sformatf("v%0d_busy_t1", v), {63'd0, busy}, 64'd1);
        if (done) lat = k;
        tick();
      end
      @(negedge clk_cpu);
      chk($sformatf("v%0d_lat", v), 64'(lat), 64'(vecs[v].lat));
      chk($sformatf("v%0d_hilo", v), hilo_q, vecs[v].exp);
      chk($sformatf("v%0d_busy_end", v), {63'd0, busy}, 64'd0);
      tick();
    end

    // mtlo then mthi in IDLE; HI comes from the last vector until mthi lands
    prev = vecs[11].exp;
    done_seen = 1'b0;
    mt_en = 1'b1; mt_hi = 1'b0; rs = 32'h0000_ABCD;
    @(negedge clk_cpu); done_seen |= done;
    tick();
    mt_hi = 1'b1; rs = 32'h0000_1234;
    @(negedge clk_cpu); done_seen |= done;
    chk("mtlo_hilo", hilo_q, {prev[63:32], 32'h0000_ABCD});
    chk("mt_busy", {63'd0, busy}, 64'd0);
    tick();
    mt_en = 1'b0; rs = '0;
    @(negedge clk_cpu); done_seen |= done;
    chk("mthi_hilo", hilo_q, 64'h0000_1234_0000_ABCD);
    tick();
    @(negedge clk_cpu); done_seen |= done;
    chk("mt_no_done", {63'd0, done_seen}, 64'd0);
    tick();

    // mfhi/mflo held from T+5 during DIV -100/7
    start = 1'b1; op = 2'b10; rs = 32'hFFFF_FF9C; rt = 32'd7;
    tick();
    start = 1'b0; rs = '0; rt = '0;
    for (int c = 1; c <= 34; c++) begin
      mf_req = (c >= 5);
      @(negedge clk_cpu);
      chk($sformatf("mf_stall_c%0d", c), {63'd0, stall_req}, {63'd0, (c >= 5 && c <= 33)});
      if (c == 34) chk("mf_hilo", hilo_q, 64'hFFFF_FFFE_FFFF_FFF2);
      tick();
    end
    mf_req = 1'b0;
    tick();

    // mthi presented while busy: stalled, applied only once the divide is done
    start = 1'b1; op = 2'b11; rs = 32'd100; rt = 32'd7;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      mt_en = (c >= 2); mt_hi = 1'b1; rs = 32'h0000_DEAD;
      @(negedge clk_cpu);
      if (c == 2 || c == 20) chk($sformatf("mt_stall_c%0d", c), {63'd0, stall_req}, 64'd1);
      if (c == 34) begin
        chk("mt_busy_hilo", hilo_q, 64'h0000_0002_0000_000E);
        chk("mt_busy_stall_end", {63'd0, stall_req}, 64'd0);
      end
      tick();
    end
    mt_en = 1'b0; rs = '0;
    @(negedge clk_cpu);
    chk("mt_after_hilo", hilo_q, 64'h0000_DEAD_0000_000E);
    tick();

    // reset asserted at T+10 of an in-flight op
    start = 1'b1; op = D_OP; rs = 32'h0000_1234; rt = 32'h0000_5678;
    tick();
    start = 1'b0; rs = '0; rt = '0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk_cpu);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", hilo_q, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      @(negedge clk_cpu);
      done_seen |= done;
    end
    chk("abort_no_done", {63'd0, done_seen}, 64'd0);
    chk("abort_hilo_later", hilo_q, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
